seq_pattern_tx: RTL

Serial pattern transmitter. It is the source end of the single-bit serial line that the team's sequence detectors (e.g. seq1010) consume. On a start request it shifts a PAT_W-bit pattern out MSB-first, one bit per clock, and repeats it a programmable number of times with an optional idle gap between repeats. It exists to drive detector stimulus and self-test loopback.

---
 rtl/seq_pattern_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first,
// repeating it a programmable number of times with an optional idle gap.
module seq_pattern_tx #(
  parameter int                 PAT_W       = 4,
  parameter logic [PAT_W-1:0]   DEFAULT_PAT = PAT_W'(4'b1010),
  parameter int                 CNT_W       = 4,
  parameter int                 GAP_W       = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_in,
  input  logic [GAP_W-1:0] gap_in,
  input  logic             abort,
  output logic             d,
  output logic             d_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [CNT_W-1:0] r_repLeft;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gapCnt;
  logic [IDX_W-1:0] r_bitIdx;
  logic             r_d;
  logic             r_dValid;
  logic             r_lastBit;
  logic             r_busy;
  logic             r_done;

  logic             w_inFlight;
  logic [IDX_W-1:0] w_nextIdx;

  assign w_inFlight = (r_state == SHIFT) || (r_state == GAP);
  assign w_nextIdx  = r_bitIdx - IDX_W'(1);

  // r_repLeft counts repetitions still to send, including the one in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= IDLE;
      r_pat     <= DEFAULT_PAT;
      r_repLeft <= '0;
      r_gap     <= '0;
      r_gapCnt  <= '0;
      r_bitIdx  <= '0;
      r_d       <= 1'b0;
      r_dValid  <= 1'b0;
      r_lastBit <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_lastBit <= 1'b0;
      if (abort && w_inFlight) begin
        r_state  <= IDLE;
        r_d      <= 1'b0;
        r_dValid <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start && !abort) begin
              r_pat     <= pat_in;
              r_repLeft <= (rep_in == '0) ? CNT_W'(1) : rep_in;
              r_gap     <= gap_in;
              r_bitIdx  <= LAST_IDX;
              r_d       <= pat_in[PAT_W-1];
              r_dValid  <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= SHIFT;
            end else begin
              r_d      <= 1'b0;
              r_dValid <= 1'b0;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end
          end
          SHIFT: begin
            if (r_bitIdx != '0) begin
              r_bitIdx  <= w_nextIdx;
              r_d       <= r_pat[w_nextIdx];
              r_lastBit <= (w_nextIdx == '0);
            end else if (r_repLeft > CNT_W'(1)) begin
              r_repLeft <= r_repLeft - CNT_W'(1);
              if (r_gap == '0) begin
                r_bitIdx <= LAST_IDX;
                r_d      <= r_pat[PAT_W-1];
              end else begin
                r_gapCnt <= r_gap;
                r_d      <= 1'b0;
                r_dValid <= 1'b0;
                r_state  <= GAP;
              end
            end else begin
              r_d      <= 1'b0;
              r_dValid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
          GAP: begin
            if (r_gapCnt == GAP_W'(1)) begin
              r_bitIdx <= LAST_IDX;
              r_d      <= r_pat[PAT_W-1];
              r_dValid <= 1'b1;
              r_state  <= SHIFT;
            end else begin
              r_gapCnt <= r_gapCnt - GAP_W'(1);
            end
          end
          default: begin
            r_d      <= 1'b0;
            r_dValid <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign d        = r_d;
  assign d_valid  = r_dValid;
  assign last_bit = r_lastBit;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
